forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_src_match.sv | 44 ++++
 rtl/forward_scoreboard.sv | 99 +++++++++
 tb/tb_forward_scoreboard.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Forwarding scoreboard shared types.
//   fwd_slot_t  : one in-flight producer (valid, destination register, ready slot).
//   FWD_SEL_RF  : select code meaning "take the value from the regfile".
//   fwd_sel_w() : select width for a given number of tracked stages.
// Slot fields are sized for the widest supported build (REG_AW <= 8,
// NUM_STAGES <= 16). Narrower register/ready values are zero-extended.
package fwd_pkg;
    localparam int FWD_DST_W  = 8;
    localparam int FWD_RDY_W  = 4;
    localparam int FWD_SEL_RF = 0;

    function automatic int fwd_sel_w(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    localparam int FWD_SEL_W = fwd_sel_w(3);

    typedef struct packed {
        logic                 valid;
        logic [FWD_DST_W-1:0] dst;
        logic [FWD_RDY_W-1:0] rdy;
    } fwd_slot_t;
endpackage

// File: rtl/fwd_src_match.sv
// Per-source-channel forwarding decision.
//   slots_i     : current scoreboard slots, index 0 = youngest (E)
//   src_reg_i   : source register read by the decode instruction
//   src_need_i  : value is consumed in decode this cycle
//   fwd_sel_o   : 0 = regfile, k+1 = result of slot k
//   stall_req_o : matched producer has not produced its result yet
module fwd_src_match import fwd_pkg::*; #(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = fwd_sel_w(NUM_STAGES)
) (
    input  fwd_slot_t [NUM_STAGES-1:0] slots_i,
    input  logic [REG_AW-1:0]          src_reg_i,
    input  logic                       src_need_i,
    output logic [SEL_W-1:0]           fwd_sel_o,
    output logic                       stall_req_o
);
    logic                 hit;
    logic [SEL_W-1:0]     hit_idx;
    logic [FWD_RDY_W-1:0] hit_rdy;

    always_comb begin
        hit         = 1'b0;
        hit_idx     = '0;
        hit_rdy     = '0;
        fwd_sel_o   = SEL_W'(FWD_SEL_RF);
        stall_req_o = 1'b0;
        // Scan oldest to youngest so the youngest matching slot wins.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (slots_i[k].valid && slots_i[k].dst == FWD_DST_W'(src_reg_i)) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
                hit_rdy = slots_i[k].rdy;
            end
        end
        // $0 is hardwired, never forwarded or waited on.
        if (hit && src_reg_i != '0) begin
            if (hit_rdy <= FWD_RDY_W'(hit_idx))
                fwd_sel_o = hit_idx + SEL_W'(1);
            else
                stall_req_o = src_need_i;
        end
    end
endmodule

// File: rtl/forward_scoreboard.sv
// Decode-stage forwarding scoreboard.
// Tracks the destination registers of the NUM_STAGES instructions behind
// decode and, per source channel, selects a bypass source or requests a stall.
//   clk, reset          : clock, synchronous active-high reset
//   id_valid/wen/dst/rdy: decode instruction and the slot its result is ready at
//   flush_i             : kill the decode instruction (never enters slot 0)
//   src_reg_i/need_i    : per-channel sources, packed channel 0 in the LSBs
//   fwd_sel_o           : per-channel bypass select, packed channel 0 in the LSBs
//   stall_o             : hold decode/fetch, bubble into slot 0
// Optional: define FWD_PERF_CNT_EN to add stall_cnt_o / fwd_cnt_o cycle counters.
module forward_scoreboard import fwd_pkg::*; #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     id_valid_i,
    input  logic                                     id_wen_i,
    input  logic [REG_AW-1:0]                        id_dst_i,
    input  logic [$clog2(NUM_STAGES)-1:0]            id_rdy_i,
    input  logic                                     flush_i,
    input  logic [NUM_SRC*REG_AW-1:0]                src_reg_i,
    input  logic [NUM_SRC-1:0]                       src_need_i,
    output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]  fwd_sel_o,
    output logic                                     stall_o
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                              stall_cnt_o,
    output logic [31:0]                              fwd_cnt_o
`endif
);
    localparam int SEL_W = fwd_sel_w(NUM_STAGES);

    fwd_slot_t [NUM_STAGES-1:0] slots_q, slots_d;
    logic [NUM_SRC-1:0]         stall_req;
    logic [NUM_SRC*SEL_W-1:0]   sel_raw;

    for (genvar c = 0; c < NUM_SRC; c++) begin : g_src
        fwd_src_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW),
            .SEL_W      (SEL_W)
        ) u_match (
            .slots_i     (slots_q),
            .src_reg_i   (src_reg_i[c*REG_AW +: REG_AW]),
            .src_need_i  (src_need_i[c]),
            .fwd_sel_o   (sel_raw[c*SEL_W +: SEL_W]),
            .stall_req_o (stall_req[c])
        );
    end

    // Outputs are forced quiet while reset is held; slots may still hold
    // pre-reset producers until the reset edge.
    always_comb begin
        stall_o   = !reset && (|stall_req);
        fwd_sel_o = reset ? '0 : sel_raw;
    end

    always_comb begin
        slots_d    = slots_q;
        slots_d[0] = '0;
        if (id_valid_i && id_wen_i && id_dst_i != '0 && !stall_o && !flush_i) begin
            slots_d[0].valid = 1'b1;
            slots_d[0].dst   = FWD_DST_W'(id_dst_i);
            slots_d[0].rdy   = FWD_RDY_W'(id_rdy_i);
        end
        for (int k = 1; k < NUM_STAGES; k++)
            slots_d[k] = slots_q[k-1];
    end

    always_ff @(posedge clk) begin
        if (reset) slots_q <= '0;
        else       slots_q <= slots_d;
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_o};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, (|fwd_sel_o)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: a default 3-stage/2-source instance and a
// 5-stage/3-source instance. Stimulus pushes the expected outputs for each
// cycle into a queue; a monitor pops and compares on the falling edge.
module tb_forward_scoreboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default instance
    logic       a_valid, a_wen, a_flush, a_stall;
    logic [4:0] a_dst;
    logic [1:0] a_rdy;
    logic [9:0] a_src;
    logic [1:0] a_need;
    logic [3:0] a_sel;
    // wide instance
    logic        b_valid, b_wen, b_flush, b_stall;
    logic [4:0]  b_dst;
    logic [2:0]  b_rdy;
    logic [14:0] b_src;
    logic [2:0]  b_need;
    logic [8:0]  b_sel;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] a_stall_cnt, a_fwd_cnt, b_stall_cnt, b_fwd_cnt;
`endif

    forward_scoreboard u_dut_a (
        .clk(clk), .reset(reset), .id_valid_i(a_valid), .id_wen_i(a_wen),
        .id_dst_i(a_dst), .id_rdy_i(a_rdy), .flush_i(a_flush),
        .src_reg_i(a_src), .src_need_i(a_need), .fwd_sel_o(a_sel), .stall_o(a_stall)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt_o(a_stall_cnt), .fwd_cnt_o(a_fwd_cnt)
`endif
    );

    forward_scoreboard #(.NUM_STAGES(5), .NUM_SRC(3), .REG_AW(5)) u_dut_b (
        .clk(clk), .reset(reset), .id_valid_i(b_valid), .id_wen_i(b_wen),
        .id_dst_i(b_dst), .id_rdy_i(b_rdy), .flush_i(b_flush),
        .src_reg_i(b_src), .src_need_i(b_need), .fwd_sel_o(b_sel), .stall_o(b_stall)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt_o(b_stall_cnt), .fwd_cnt_o(b_fwd_cnt)
`endif
    );

    typedef struct {
        int         dut;    // 0 = default, 1 = wide, 2 = no check
        logic       stall;
        logic [8:0] sel;
        string      name;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic       act_st;
            logic [8:0] act_sel;
            e = q.pop_front();
            if (e.dut != 2) begin
                act_st  = (e.dut == 0) ? a_stall : b_stall;
                act_sel = (e.dut == 0) ? 9'(a_sel) : b_sel;
                n_cmp++;
                if (act_st !== e.stall || act_sel !== e.sel) begin
                    n_bad++;
                    $display("FAIL %s: stall=%b sel=%h, expected stall=%b sel=%h",
                             e.name, act_st, act_sel, e.stall, e.sel);
                end
            end
        end
    end

    function automatic logic [8:0] sa(input logic [1:0] rs, input logic [1:0] rt);
        return {5'd0, rt, rs};
    endfunction

    task automatic step(input int dut, input logic st, input logic [8:0] sel, input string nm);
        exp_t e;
        e.dut = dut; e.stall = st; e.sel = sel; e.name = nm;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic da(input logic v, input logic w, input logic [4:0] dst, input logic [1:0] rdy,
                      input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                      input logic nrs, input logic nrt);
        a_valid = v; a_wen = w; a_dst = dst; a_rdy = rdy; a_flush = fl;
        a_src = {rt, rs}; a_need = {nrt, nrs};
    endtask

    task automatic drain();
        da(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(2, 0, 0, "drain");
    endtask

    initial begin
        reset = 1'b1;
        da(1, 1, 3, 0, 0, 3, 0, 1, 0);
        b_valid = 0; b_wen = 0; b_dst = 0; b_rdy = 0; b_flush = 0; b_src = 0; b_need = 0;
        @(posedge clk); #1;
        step(0, 0, 0, "rst_hold");
        step(1, 0, 0, "rst_hold_b");
        reset = 1'b0;
        da(0, 0, 0, 0, 0, 3, 0, 1, 0);
        step(0, 0, 0, "post_rst");

        // ALU producer forwarded from E, then M, then W
        da(1, 1, 3, 0, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "addu_e");
        da(1, 0, 0, 0, 0, 3, 0, 1, 1); step(0, 0, sa(1, 0), "beq_rs_e");
        da(0, 0, 0, 0, 0, 3, 0, 1, 0); step(0, 0, sa(2, 0), "rs_m");
        step(0, 0, sa(3, 0), "rs_w_last");
        step(0, 0, sa(0, 0), "rs_gone");
        drain();

        // load-use: one stall, then forward from M
        da(1, 1, 5, 1, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "lw_e");
        da(1, 0, 0, 0, 0, 0, 5, 1, 1); step(0, 1, sa(0, 0), "lw_stall");
        step(0, 0, sa(0, 2), "lw_rt_m");
        da(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "lw_done");
        drain();

        // flush: killed producer never enters; flush+stall keeps older slots
        da(1, 1, 9, 0, 1, 0, 0, 0, 0); step(0, 0, sa(0, 0), "flush_prod");
        da(1, 0, 0, 0, 0, 9, 0, 1, 0); step(0, 0, sa(0, 0), "flushed_nofwd");
        drain();
        da(1, 1, 8, 1, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "lw8");
        da(1, 1, 10, 0, 1, 8, 0, 1, 0); step(0, 1, sa(0, 0), "flush_stall");
        da(1, 0, 0, 0, 0, 10, 8, 1, 1); step(0, 0, sa(0, 2), "flush_old_kept");
        drain();

        // youngest match wins; $0 never forwarded
        da(1, 1, 7, 0, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "p7a");
        da(1, 1, 1, 0, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "p1");
        da(1, 1, 7, 0, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "p7b");
        da(1, 0, 0, 0, 0, 7, 1, 1, 1); step(0, 0, sa(1, 2), "youngest7");
        da(1, 1, 0, 0, 0, 0, 0, 1, 1); step(0, 0, sa(0, 0), "dst0_prod");
        da(1, 0, 0, 0, 0, 0, 7, 1, 1); step(0, 0, sa(0, 3), "src0_and_w");
        drain();

        // unready producer, value not needed: no stall, no forward
        da(1, 1, 4, 1, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "lw4");
        da(1, 0, 0, 0, 0, 4, 0, 0, 0); step(0, 0, sa(0, 0), "noneed");
        da(1, 0, 0, 0, 0, 4, 0, 1, 0); step(0, 0, sa(2, 0), "need_m");
        drain();

        // reset while stalled drops in-flight producers
        da(1, 1, 2, 1, 0, 0, 0, 0, 0); step(0, 0, sa(0, 0), "lw2");
        da(1, 1, 6, 0, 0, 2, 0, 1, 0); step(0, 1, sa(0, 0), "pre_rst_stall");
        reset = 1'b1;
        step(0, 0, sa(0, 0), "rst_mid_stall");
        reset = 1'b0;
`ifdef FWD_PERF_CNT_EN
        n_cmp++;
        if (a_stall_cnt !== 32'd0 || a_fwd_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL cnt_after_rst: stall_cnt=%0d fwd_cnt=%0d, expected 0 0", a_stall_cnt, a_fwd_cnt);
        end
`endif
        step(0, 0, sa(0, 0), "post_rst_empty");
        da(1, 0, 0, 0, 0, 2, 6, 1, 1); step(0, 0, sa(0, 1), "post_rst_new");
        drain();

        // wide instance: rdy=3 producer -> three stalls, then slot 3 and 4
        b_valid = 1; b_wen = 1; b_dst = 11; b_rdy = 3;
        step(1, 0, 0, "b_prod");
        b_wen = 0; b_dst = 0; b_rdy = 0;
        b_src = {5'd11, 5'd0, 5'd11}; b_need = 3'b100;
        step(1, 1, 0, "b_stall1");
        step(1, 1, 0, "b_stall2");
        step(1, 1, 0, "b_stall3");
        step(1, 0, {3'd4, 3'd0, 3'd4}, "b_fwd4");
        step(1, 0, {3'd5, 3'd0, 3'd5}, "b_fwd5_last");
        step(1, 0, 9'd0, "b_gone");

        @(posedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
